// File: rtl/chip_pkg.sv
// Shared constants, FSM encoding and the saturating magnitude helper for the
// chip scan scheduler.
package chip_pkg;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int IW  = $clog2(NCH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2,
    ST_NEXT   = 2'd3
  } state_e;

  localparam logic [DW-1:0] MAG_SAT = 16'h7FFF;

  function automatic logic [DW-1:0] sat_mag(input logic [DW-1:0] d);
    logic [DW-1:0] neg;
    neg = -d;
    if (!d[DW-1]) return d;
    // Only the most negative code negates back to a negative value.
    if (neg[DW-1]) return MAG_SAT;
    return neg;
  endfunction

endpackage

// File: rtl/chip_rr_pick.sv
// Combinational finder for the lowest enabled channel, either overall
// (first_i) or strictly above cur_i.
module chip_rr_pick
  import chip_pkg::*;
(
  input  logic [NCH-1:0] mask_i,
  input  logic [IW-1:0]  cur_i,
  input  logic           first_i,
  output logic [IW-1:0]  nxt_o,
  output logic           vld_o
);

  logic [NCH-1:0] cand;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    assign cand[gi] = mask_i[gi] && (first_i || (IW'(gi) > cur_i));
  end

  // Descending walk so the lowest candidate is the one left standing.
  always_comb begin
    nxt_o = '0;
    vld_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nxt_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chip_scan_ctrl.sv
// Scan scheduler: walks cfg_path_sel over the enabled channels, discards
// settling samples, measures peak magnitude and publishes hit map and best.
module chip_scan_ctrl
  import chip_pkg::*;
#(
  parameter int unsigned SETTLE_SMP = 2
) (
  input  logic           clk_sys,
  input  logic           rst,
  input  logic           scan_start,
  input  logic           scan_stop,
  input  logic [NCH-1:0] cfg_chan_mask,
  input  logic [DW-1:0]  cfg_dwell,
  input  logic [DW-1:0]  cfg_chip_th,
  input  logic           cfg_scan_cont,
  input  logic [DW-1:0]  d1_data,
  input  logic           d1_vld,
  output logic [7:0]     cfg_path_sel,
  output logic           scan_busy,
  output logic           scan_done,
  output logic [NCH-1:0] hit_map,
  output logic [IW-1:0]  peak_chan,
  output logic [DW-1:0]  peak_val
);

  localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE_SMP - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  path_q, path_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DW-1:0]  th_q, th_d;
  logic           cont_q, cont_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  chan_peak_q, chan_peak_d;
  logic [NCH-1:0] hit_work_q, hit_work_d;
  logic [IW-1:0]  best_chan_q, best_chan_d;
  logic [DW-1:0]  best_val_q, best_val_d;
  logic [NCH-1:0] hit_map_q, hit_map_d;
  logic [IW-1:0]  peak_chan_q, peak_chan_d;
  logic [DW-1:0]  peak_val_q, peak_val_d;
  logic           done_q, done_d;

  logic [IW-1:0]  first_idx, next_idx;
  logic           first_vld, next_vld;
  logic [DW-1:0]  mag;
  logic           launch;
  logic [NCH-1:0] hit_upd;
  logic [IW-1:0]  best_chan_upd;
  logic [DW-1:0]  best_val_upd;

  chip_rr_pick u_pick_first (
    .mask_i (cfg_chan_mask),
    .cur_i  ('0),
    .first_i(1'b1),
    .nxt_o  (first_idx),
    .vld_o  (first_vld)
  );

  chip_rr_pick u_pick_next (
    .mask_i (mask_q),
    .cur_i  (path_q),
    .first_i(1'b0),
    .nxt_o  (next_idx),
    .vld_o  (next_vld)
  );

  assign mag = sat_mag(d1_data);

  // Scan-completion view of the working results including the current channel.
  always_comb begin
    hit_upd = hit_work_q;
    if (chan_peak_q >= th_q) hit_upd[path_q] = 1'b1;
    best_chan_upd = best_chan_q;
    best_val_upd  = best_val_q;
    if (chan_peak_q > best_val_q) begin
      best_chan_upd = path_q;
      best_val_upd  = chan_peak_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    path_d      = path_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    th_d        = th_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    chan_peak_d = chan_peak_q;
    hit_work_d  = hit_work_q;
    best_chan_d = best_chan_q;
    best_val_d  = best_val_q;
    hit_map_d   = hit_map_q;
    peak_chan_d = peak_chan_q;
    peak_val_d  = peak_val_q;
    done_d      = 1'b0;
    launch      = 1'b0;

    if (state_q != ST_IDLE && scan_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_start && !scan_stop) begin
            if (first_vld) begin
              launch = 1'b1;
            end else begin
              done_d      = 1'b1;
              hit_map_d   = '0;
              peak_chan_d = '0;
              peak_val_d  = '0;
            end
          end
        end
        ST_SETTLE: begin
          if (d1_vld) begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_d   = '0;
              state_d = ST_DWELL;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DWELL: begin
          if (d1_vld) begin
            if (mag > chan_peak_q) chan_peak_d = mag;
            if (cnt_q == dwell_q - 1'b1) begin
              cnt_d   = '0;
              state_d = ST_NEXT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_NEXT: begin
          hit_work_d  = hit_upd;
          best_chan_d = best_chan_upd;
          best_val_d  = best_val_upd;
          if (next_vld) begin
            path_d      = next_idx;
            chan_peak_d = '0;
            cnt_d       = '0;
            state_d     = ST_SETTLE;
          end else begin
            hit_map_d   = hit_upd;
            peak_chan_d = best_chan_upd;
            peak_val_d  = best_val_upd;
            done_d      = 1'b1;
            if (cont_q && first_vld) launch = 1'b1;
            else state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Shared by a fresh start and a continuous-mode restart.
    if (launch) begin
      mask_d      = cfg_chan_mask;
      dwell_d     = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
      th_d        = cfg_chip_th;
      cont_d      = cfg_scan_cont;
      path_d      = first_idx;
      cnt_d       = '0;
      chan_peak_d = '0;
      hit_work_d  = '0;
      best_chan_d = first_idx;
      best_val_d  = '0;
      state_d     = ST_SETTLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      path_q      <= '0;
      mask_q      <= '0;
      dwell_q     <= '0;
      th_q        <= '0;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      chan_peak_q <= '0;
      hit_work_q  <= '0;
      best_chan_q <= '0;
      best_val_q  <= '0;
      hit_map_q   <= '0;
      peak_chan_q <= '0;
      peak_val_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      path_q      <= path_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      th_q        <= th_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      chan_peak_q <= chan_peak_d;
      hit_work_q  <= hit_work_d;
      best_chan_q <= best_chan_d;
      best_val_q  <= best_val_d;
      hit_map_q   <= hit_map_d;
      peak_chan_q <= peak_chan_d;
      peak_val_q  <= peak_val_d;
      done_q      <= done_d;
    end
  end

  assign cfg_path_sel = 8'(path_q);
  assign scan_busy    = (state_q != ST_IDLE);
  assign scan_done    = done_q;
  assign hit_map      = hit_map_q;
  assign peak_chan    = peak_chan_q;
  assign peak_val     = peak_val_q;

endmodule

// File: tb/tb_chip_scan_ctrl.sv
// Directed bench for chip_scan_ctrl: expected scan results are queued when a
// scan is launched and checked when scan_done fires.
module tb_chip_scan_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        scan_start = 1'b0;
  logic        scan_stop = 1'b0;
  logic [7:0]  cfg_chan_mask = '0;
  logic [15:0] cfg_dwell = '0;
  logic [15:0] cfg_chip_th = '0;
  logic        cfg_scan_cont = 1'b0;
  logic [15:0] d1_data = '0;
  logic        d1_vld = 1'b0;
  logic [7:0]  cfg_path_sel;
  logic        scan_busy;
  logic        scan_done;
  logic [7:0]  hit_map;
  logic [2:0]  peak_chan;
  logic [15:0] peak_val;

  typedef struct {
    logic [7:0]  hit;
    logic [2:0]  chan;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  chip_scan_ctrl dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .scan_start   (scan_start),
    .scan_stop    (scan_stop),
    .cfg_chan_mask(cfg_chan_mask),
    .cfg_dwell    (cfg_dwell),
    .cfg_chip_th  (cfg_chip_th),
    .cfg_scan_cont(cfg_scan_cont),
    .d1_data      (d1_data),
    .d1_vld       (d1_vld),
    .cfg_path_sel (cfg_path_sel),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done),
    .hit_map      (hit_map),
    .peak_chan    (peak_chan),
    .peak_val     (peak_val)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic send(input logic [15:0] d);
    d1_data = d;
    d1_vld  = 1'b1;
    tick();
    d1_vld  = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] m, input logic [15:0] dw,
                         input logic [15:0] th, input logic c);
    cfg_chan_mask = m;
    cfg_dwell     = dw;
    cfg_chip_th   = th;
    cfg_scan_cont = c;
  endtask

  task automatic start_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] h, input logic [2:0] c, input logic [15:0] v);
    exp_t e;
    e.hit = h; e.chan = c; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    for (int i = 0; i < budget && scan_done !== 1'b1; i++) tick();
    chk({tag, "_done"}, {31'd0, scan_done}, 32'd1);
    e = exp_q.pop_front();
    chk({tag, "_hit"}, {24'd0, hit_map}, {24'd0, e.hit});
    chk({tag, "_chan"}, {29'd0, peak_chan}, {29'd0, e.chan});
    chk({tag, "_val"}, {16'd0, peak_val}, {16'd0, e.val});
  endtask

  initial begin
    logic seen;
    tick(); tick();
    rst = 1'b0;
    chk("rst_path", {24'd0, cfg_path_sel}, 32'd0);
    chk("rst_busy", {31'd0, scan_busy}, 32'd0);
    chk("rst_done", {31'd0, scan_done}, 32'd0);
    chk("rst_hit", {24'd0, hit_map}, 32'd0);
    chk("rst_pval", {16'd0, peak_val}, 32'd0);

    // Two-channel scan, ch0 hits on a negative sample, ch2 stays under threshold
    set_cfg(8'h05, 16'd4, 16'd100, 1'b0);
    push_exp(8'h01, 3'd0, 16'd120);
    start_scan();
    chk("t1_busy", {31'd0, scan_busy}, 32'd1);
    chk("t1_path0", {24'd0, cfg_path_sel}, 32'd0);
    send(16'd0); send(16'd0);
    send(16'd10); send(-16'sd120); send(16'd50); send(16'd3);
    tick();
    chk("t1_path2", {24'd0, cfg_path_sel}, 32'd2);
    send(16'd0); send(16'd0);
    for (int i = 0; i < 4; i++) send(16'd99);
    wait_done("t1", 4);
    chk("t1_idle", {31'd0, scan_busy}, 32'd0);
    tick();
    chk("t1_single", {31'd0, scan_done}, 32'd0);

    // Settle samples of 0x8000 must be discarded
    set_cfg(8'h01, 16'd4, 16'd100, 1'b0);
    push_exp(8'h00, 3'd0, 16'd5);
    start_scan();
    send(16'h8000); send(16'h8000);
    for (int i = 0; i < 4; i++) send(16'd5);
    wait_done("t2a", 4);

    // 0x8000 inside the dwell saturates to 0x7FFF
    push_exp(8'h01, 3'd0, 16'h7FFF);
    start_scan();
    send(16'd5); send(16'd5);
    send(16'd5); send(16'h8000); send(16'd5); send(16'd5);
    wait_done("t2b", 4);

    // Empty mask: immediate done and cleared results
    set_cfg(8'h00, 16'd4, 16'd100, 1'b0);
    push_exp(8'h00, 3'd0, 16'd0);
    start_scan();
    chk("t3_busy", {31'd0, scan_busy}, 32'd0);
    wait_done("t3", 0);
    tick();
    chk("t3_single", {31'd0, scan_done}, 32'd0);

    // Start and stop together in IDLE: stop wins
    set_cfg(8'h01, 16'd1, 16'd0, 1'b0);
    scan_start = 1'b1; scan_stop = 1'b1;
    tick();
    scan_start = 1'b0; scan_stop = 1'b0;
    chk("ss_busy", {31'd0, scan_busy}, 32'd0);
    chk("ss_done", {31'd0, scan_done}, 32'd0);

    // Equal peaks on ch1 and ch4 at threshold: both hit, lower channel wins
    set_cfg(8'h12, 16'd2, 16'd500, 1'b0);
    push_exp(8'h12, 3'd1, 16'd500);
    start_scan();
    chk("tie_path1", {24'd0, cfg_path_sel}, 32'd1);
    send(16'd0); send(16'd0); send(16'd500); send(16'd3);
    tick();
    chk("tie_path4", {24'd0, cfg_path_sel}, 32'd4);
    send(16'd0); send(16'd0); send(-16'sd500); send(16'd100);
    wait_done("tie", 4);

    // Abort during DWELL of ch3
    set_cfg(8'hFF, 16'd1, 16'd0, 1'b0);
    start_scan();
    for (int c = 0; c < 3; c++) begin
      send(16'd0); send(16'd0); send(16'd7);
      tick();
    end
    send(16'd0); send(16'd0);
    chk("stop_path_pre", {24'd0, cfg_path_sel}, 32'd3);
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
    chk("stop_busy", {31'd0, scan_busy}, 32'd0);
    chk("stop_path", {24'd0, cfg_path_sel}, 32'd3);
    chk("stop_hit", {24'd0, hit_map}, 32'h12);
    chk("stop_chan", {29'd0, peak_chan}, 32'd1);
    seen = scan_done;
    for (int i = 0; i < 6; i++) begin
      send(16'd9);
      seen = seen | scan_done;
    end
    chk("stop_nodone", {31'd0, seen}, 32'd0);

    // Continuous mode; mask change takes effect only at the restart
    set_cfg(8'h81, 16'd0, 16'd10, 1'b1);
    push_exp(8'h81, 3'd7, 16'd30);
    start_scan();
    chk("cont_path0", {24'd0, cfg_path_sel}, 32'd0);
    send(16'd0); send(16'd0);
    cfg_chan_mask = 8'h02;
    send(16'd20);
    tick();
    chk("cont_path7", {24'd0, cfg_path_sel}, 32'd7);
    send(16'd0); send(16'd0); send(16'd30);
    wait_done("cont1", 4);
    chk("cont_restart_busy", {31'd0, scan_busy}, 32'd1);
    chk("cont_restart_path", {24'd0, cfg_path_sel}, 32'd1);
    push_exp(8'h02, 3'd1, 16'd40);
    send(16'd0); send(16'd0); send(16'd40);
    wait_done("cont2", 4);
    chk("cont_again_busy", {31'd0, scan_busy}, 32'd1);
    cfg_scan_cont = 1'b0;
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
    chk("cont_stop_busy", {31'd0, scan_busy}, 32'd0);

    // Reset in the middle of DWELL
    set_cfg(8'h12, 16'd4, 16'd0, 1'b0);
    start_scan();
    send(16'd0); send(16'd0); send(16'd9);
    rst = 1'b1;
    tick();
    chk("mrst_path", {24'd0, cfg_path_sel}, 32'd0);
    chk("mrst_busy", {31'd0, scan_busy}, 32'd0);
    chk("mrst_done", {31'd0, scan_done}, 32'd0);
    chk("mrst_hit", {24'd0, hit_map}, 32'd0);
    chk("mrst_chan", {29'd0, peak_chan}, 32'd0);
    chk("mrst_pval", {16'd0, peak_val}, 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_scan_ctrl.md
Name: chip_scan_ctrl

Overview:
Scan scheduler for the 8-channel chip datapath selector. It steps cfg_path_sel through an enabled channel mask and waits out path settling after each switch. It then measures peak magnitude on the selected stream over a programmable dwell. The result is a per-scan hit map against cfg_chip_th, plus the strongest channel, for the chip-detect logic.

Parameters:
NCH, 8, number of selectable channels (cfg_path_sel codes 0..NCH-1)
SETTLE_SMP, 2, valid samples discarded after every path switch
DW, 16, sample width

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous, active-high reset
scan_start  in  1  single-cycle pulse: begin a scan
scan_stop  in  1  single-cycle pulse: abort scan
cfg_chan_mask  in  8  channel enable bits, bit i = sm(i+1)
cfg_dwell  in  16  valid samples measured per channel (0 treated as 1)
cfg_chip_th  in  16  unsigned magnitude threshold
cfg_scan_cont  in  1  1 = restart automatically after each completed scan
d1_data  in  16  selected-path sample, signed two's complement
d1_vld  in  1  sample strobe on d1_data
cfg_path_sel  out  8  channel select driven into the datapath selector
scan_busy  out  1  high while not IDLE
scan_done  out  1  one-cycle pulse at end of each complete scan
hit_map  out  8  bit i set if channel i peak >= threshold in last completed scan
peak_chan  out  3  channel with largest peak in last completed scan
peak_val  out  16  that peak magnitude

Behaviour:
- Reset values: cfg_path_sel=0, scan_busy=0, scan_done=0, hit_map=0, peak_chan=0, peak_val=0. FSM in IDLE. All counters cleared.
- States: IDLE, SETTLE, DWELL, NEXT.
- IDLE: on scan_start with mask!=0, latch mask, dwell, th and cont into shadow registers. Pick the lowest enabled channel, register it onto cfg_path_sel the next cycle, and go to SETTLE. On scan_start with mask==0, stay IDLE, pulse scan_done, and clear hit_map/peak_*.
- SETTLE: count d1_vld. After SETTLE_SMP valid samples have been discarded, go to DWELL. Samples arriving in the cycle cfg_path_sel changes count as discarded.
- DWELL: on each d1_vld compute mag = |d1_data|, with -32768 saturating to 32767. Keep chan_peak = max. After dwell_cnt valid samples, go to NEXT. The final sample is included in the peak.
- NEXT (1 cycle):
  - Set working hit bit i if chan_peak >= th (>=, not >).
  - Update the working best if chan_peak > best. On a tie the lower channel index wins.
  - Find the next enabled channel above the current one (round-robin, no wrap within a scan).
  - If one exists: update cfg_path_sel, clear chan_peak, go to SETTLE.
  - Otherwise, scan complete: copy working regs to hit_map/peak_chan/peak_val, pulse scan_done. If cont, restart from the lowest enabled channel using the re-latched current cfg_* inputs (SETTLE); else go to IDLE.
- Outputs hit_map/peak_* change only at scan completion and hold until the next completion or reset.
- scan_stop: in any non-IDLE state, go to IDLE next cycle. No scan_done, outputs unchanged, cfg_path_sel holds its last value.
- scan_start while busy: ignored. Simultaneous start and stop in IDLE: stop wins, no scan.
- Config inputs may change mid-scan with no effect until the next latch.
- rst asserted mid-scan: all state returns to reset values on that edge.
- Single-channel mask: scan = SETTLE, DWELL, NEXT on that channel only.
- Minimum scan latency per channel: SETTLE_SMP + dwell valid samples + 2 cycles (select register + NEXT).

Decomposition:
- Package chip_pkg: NCH, DW, the FSM state encoding (IDLE=0, SETTLE=1, DWELL=2, NEXT=3), and the magnitude-saturation constant 16'h7FFF.
- Sub-module chip_rr_pick: combinational next-enabled-channel finder.
  - Inputs: mask, current index, first flag.
  - Outputs: next index, valid.
  - Reused for the lowest-enabled pick at scan start.

Test Plan:
- mask=8'h05, dwell=4, th=100. ch0 samples {10,-120,50,3}, ch2 samples {99,99,99,99} -> cfg_path_sel visits 0 then 2; hit_map=8'h01; peak_chan=0; peak_val=120; single scan_done; busy drops.
- Settle discard: after each switch, feed first 2 samples = 16'h8000, then four samples of 5 -> peak_val=5. Also feed ch sample 16'h8000 inside dwell -> peak 16'h7FFF.
- mask=8'h00 start -> scan_done pulse the next cycle, busy stays 0, hit_map=0.
- scan_stop during DWELL of channel 3 (mask=8'hFF) -> IDLE next cycle, no scan_done, hit_map keeps previous value, cfg_path_sel stays 3.
- cfg_scan_cont=1, mask=8'h81, dwell=0 -> each channel measures 1 sample; scan_done pulses repeatedly. Change mask to 8'h02 mid-scan -> takes effect only after the next scan_done.
- Tie: ch1 and ch4 both peak 500, th=500 -> hit_map=8'h12, peak_chan=1. Assert rst mid-DWELL -> all outputs return to 0 on the next edge.
